// File: rtl/ex_mul_div_unit_if.sv
// EX-stage handshake between the pipeline and the iterative multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface ex_mul_div_unit_if #(
   parameter int XLEN = 64
);
   logic            valid_i;
   logic [3:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            stall_req_o;
   logic [XLEN-1:0] result_o;
   logic            result_valid_o;

   modport master (
      output valid_i, op_i, rs1_i, rs2_i, flush_i,
      input  stall_req_o, result_o, result_valid_o
   );

   modport slave (
      input  valid_i, op_i, rs1_i, rs2_i, flush_i,
      output stall_req_o, result_o, result_valid_o
   );
endinterface

// File: rtl/ex_mul_div_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider on one hi/lo datapath, working on magnitudes with a final sign correction.
module ex_mul_div_unit #(
   parameter int XLEN = 64
) (
   input logic               clk,
   input logic               rst,
   ex_mul_div_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [6:0]      cnt;
   logic [XLEN-1:0] hi, lo, b_reg, result_q;
   logic            is_div_q, is_rem_q, want_hi_q, is_w_q, neg_q, rneg_q;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   // Decode and operand preparation for the starting instruction
   logic            is_w, is_div, is_rem, want_hi, signed_a, signed_b;
   logic [2:0]      f3;
   logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, dividend, special_res;
   logic            a_neg, b_neg, div_zero, div_ovf, special;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      f3       = bus.op_i[2:0];
      is_w     = bus.op_i[3];
      is_div   = f3[2];
      is_rem   = f3[2] & f3[1];
      want_hi  = ~f3[2] & (f3[1:0] != 2'b00);
      signed_a = is_div ? ~f3[0] : (f3[1:0] != 2'b11);
      signed_b = is_div ? ~f3[0] : ~f3[1];

      a_ext = bus.rs1_i;
      b_ext = bus.rs2_i;
      if (is_w) begin
         a_ext = signed_a ? sext32(bus.rs1_i[31:0]) : {{(XLEN-32){1'b0}}, bus.rs1_i[31:0]};
         b_ext = signed_b ? sext32(bus.rs2_i[31:0]) : {{(XLEN-32){1'b0}}, bus.rs2_i[31:0]};
      end
      a_neg = signed_a & a_ext[XLEN-1];
      b_neg = signed_b & b_ext[XLEN-1];
      mag_a = a_neg ? -a_ext : a_ext;
      mag_b = b_neg ? -b_ext : b_ext;

      dividend = is_w ? sext32(bus.rs1_i[31:0]) : bus.rs1_i;
      div_zero = is_w ? (bus.rs2_i[31:0] == 32'd0) : (bus.rs2_i == '0);
      div_ovf  = ~f3[0] & (is_w ? (bus.rs1_i[31:0] == 32'h8000_0000 && bus.rs2_i[31:0] == '1)
                                : (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_i == '1));
      special  = is_div & (div_zero | div_ovf);

      // On overflow the dividend is min_int, which is also the required quotient
      if (div_zero) special_res = is_rem ? dividend : '1;
      else          special_res = is_rem ? '0 : dividend;
   end

   // One iteration of the shared datapath plus the sign-corrected final result
   logic [XLEN:0]     mul_sum, div_sh;
   logic [XLEN-1:0]   hi_n, lo_n, q_c, r_c, div_res, final_res;
   logic [2*XLEN-1:0] prod_c;
   logic [31:0]       mulw_c;
   logic              q_bit;

   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
      div_sh  = {hi, lo[XLEN-1]};
      q_bit   = (div_sh >= {1'b0, b_reg});
      if (is_div_q) begin
         hi_n = q_bit ? (div_sh[XLEN-1:0] - b_reg) : div_sh[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], q_bit};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo[XLEN-1:1]};
      end

      prod_c  = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      mulw_c  = neg_q ? -lo_n[XLEN-1:XLEN-32] : lo_n[XLEN-1:XLEN-32];
      q_c     = neg_q ? -lo_n : lo_n;
      r_c     = rneg_q ? -hi_n : hi_n;
      div_res = is_rem_q ? r_c : q_c;

      if (is_div_q)       final_res = is_w_q ? sext32(div_res[31:0]) : div_res;
      else if (is_w_q)    final_res = sext32(mulw_c);
      else if (want_hi_q) final_res = prod_c[2*XLEN-1:XLEN];
      else                final_res = prod_c[XLEN-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         b_reg     <= '0;
         result_q  <= '0;
         is_div_q  <= 1'b0;
         is_rem_q  <= 1'b0;
         want_hi_q <= 1'b0;
         is_w_q    <= 1'b0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
      end else if (bus.flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (bus.valid_i) begin
               is_div_q  <= is_div;
               is_rem_q  <= is_rem;
               want_hi_q <= want_hi;
               is_w_q    <= is_w;
               neg_q     <= a_neg ^ b_neg;
               rneg_q    <= a_neg;
               if (special) begin
                  result_q <= special_res;
                  state    <= DONE;
               end else begin
                  state <= CALC;
                  cnt   <= is_w ? 7'd32 : 7'(XLEN);
                  hi    <= '0;
                  if (is_div) begin
                     // W divides only iterate 32 times, so left-align the dividend
                     lo    <= is_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                     b_reg <= mag_b;
                  end else begin
                     lo    <= mag_b;
                     b_reg <= mag_a;
                  end
               end
            end
            CALC: begin
               hi  <= hi_n;
               lo  <= lo_n;
               cnt <= cnt - 7'd1;
               if (cnt == 7'd1) begin
                  result_q <= final_res;
                  state    <= DONE;
               end
            end
            // valid_i here still belongs to the completing instruction
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall_req_o    = ~rst & bus.valid_i & ~bus.flush_i & (state != DONE);
   assign bus.result_valid_o = (state == DONE);
   assign bus.result_o       = result_q;

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Directed self-checking bench for ex_mul_div_unit: arithmetic, latency, special
// cases, flush, asynchronous reset mid-operation and back-to-back issue.
module tb_ex_mul_div_unit;
   localparam int XLEN = 64;
   localparam logic [3:0] OP_MUL = 4'h0, OP_MULH = 4'h1, OP_MULHSU = 4'h2, OP_MULHU = 4'h3,
                          OP_DIV = 4'h4, OP_DIVU = 4'h5, OP_REM = 4'h6, OP_REMU = 4'h7,
                          OP_MULW = 4'h8, OP_DIVW = 4'hC, OP_DIVUW = 4'hD;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ex_mul_div_unit_if #(.XLEN(XLEN)) bus ();
   ex_mul_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Issue one op from a falling edge; cycle 0 is the issue cycle
   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int vcyc, output int nstall);
      res = '0; vcyc = -1; nstall = 0;
      @(negedge clk);
      bus.valid_i = 1'b1; bus.op_i = op; bus.rs1_i = a; bus.rs2_i = b;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (bus.stall_req_o) nstall++;
         if (bus.result_valid_o) begin
            vcyc = c;
            res  = bus.result_o;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      bus.valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.valid_i = 1'b1; bus.op_i = OP_MUL; bus.rs1_i = 64'd3; bus.rs2_i = 64'd5; bus.flush_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (bus.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_req_o); end
      n_checks++;
      if (bus.result_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.result_valid_o); end
      n_checks++;
      if (bus.result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
      @(negedge clk);
      bus.valid_i = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_mul();
      logic [3:0]  ops [5] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_MUL};
      logic [63:0] as  [5] = '{64'd3, ONES, ONES, ONES, 64'h0000_0001_0000_0003};
      logic [63:0] bs  [5] = '{64'hFFFF_FFFF_FFFF_FFFB, ONES, ONES, 64'd2, 64'h0000_0002_0000_0005};
      logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, ONES,
                               64'h0000_000B_0000_000F};
      logic [63:0] res;
      int vcyc, nstall;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], res, vcyc, nstall);
         n_checks++;
         if (res !== exp[i]) begin n_fail++; $display("FAIL mul[%0d]: got %h want %h", i, res, exp[i]); end
         if (i == 0) begin
            n_checks++;
            if (vcyc != 65) begin n_fail++; $display("FAIL mul_latency: valid at cycle %0d want 65", vcyc); end
            n_checks++;
            if (nstall != 65) begin n_fail++; $display("FAIL mul_stall: %0d stall cycles want 65", nstall); end
         end
      end
   endtask

   task automatic test_div();
      logic [3:0]  ops [5] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_REM};
      logic [63:0] as  [5] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100, 64'd7};
      logic [63:0] bs  [5] = '{64'd2, 64'd2, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
      logic [63:0] exp [5] = '{64'hFFFF_FFFF_FFFF_FFFD, ONES, 64'd14, 64'd2, 64'd1};
      logic [63:0] res;
      int vcyc, nstall;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], res, vcyc, nstall);
         n_checks++;
         if (res !== exp[i]) begin n_fail++; $display("FAIL div[%0d]: got %h want %h", i, res, exp[i]); end
         if (i == 0) begin
            n_checks++;
            if (vcyc != 65) begin n_fail++; $display("FAIL div_latency: valid at cycle %0d want 65", vcyc); end
         end
      end
   endtask

   task automatic test_special();
      logic [3:0]  ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
      logic [63:0] as  [4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, MIN, MIN};
      logic [63:0] bs  [4] = '{64'd0, 64'd0, ONES, ONES};
      logic [63:0] exp [4] = '{ONES, 64'h1234_5678_9ABC_DEF0, MIN, 64'd0};
      logic [63:0] res;
      int vcyc, nstall;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], res, vcyc, nstall);
         n_checks++;
         if (res !== exp[i]) begin n_fail++; $display("FAIL special[%0d]: got %h want %h", i, res, exp[i]); end
         n_checks++;
         if (vcyc != 1 || nstall != 1) begin
            n_fail++;
            $display("FAIL special_latency[%0d]: valid cycle %0d stalls %0d want 1 and 1", i, vcyc, nstall);
         end
      end
   endtask

   task automatic test_word();
      logic [3:0]  ops [4] = '{OP_DIVW, OP_DIVUW, OP_MULW, OP_DIVW};
      logic [63:0] as  [4] = '{64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF,
                               64'hDEAD_0000_FFFF_FFF9};
      logic [63:0] bs  [4] = '{64'd1, 64'd1, 64'd2, 64'h1234_5678_0000_0002};
      logic [63:0] exp [4] = '{64'hFFFF_FFFF_8000_0000, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
      logic [63:0] res;
      int vcyc, nstall;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], res, vcyc, nstall);
         n_checks++;
         if (res !== exp[i]) begin n_fail++; $display("FAIL word[%0d]: got %h want %h", i, res, exp[i]); end
         if (i == 0) begin
            n_checks++;
            if (vcyc != 33 || nstall != 33) begin
               n_fail++;
               $display("FAIL word_latency: valid cycle %0d stalls %0d want 33 and 33", vcyc, nstall);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [63:0] res;
      int vcyc, nstall;
      bit seen_rv = 1'b0;
      run_op(OP_DIVU, 64'd100, 64'd7, res, vcyc, nstall);
      @(negedge clk);
      bus.valid_i = 1'b1; bus.op_i = OP_DIV; bus.rs1_i = 64'd1000; bus.rs2_i = 64'd10;
      repeat (10) @(negedge clk);
      bus.flush_i = 1'b1;
      #1;
      n_checks++;
      if (bus.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.stall_req_o); end
      @(negedge clk);
      bus.flush_i = 1'b0; bus.valid_i = 1'b0;
      for (int c = 0; c < 80; c++) begin
         #1;
         if (bus.result_valid_o) seen_rv = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (seen_rv) begin n_fail++; $display("FAIL flush_no_valid: result_valid seen after flush, want none"); end
      n_checks++;
      if (bus.result_o !== 64'd14) begin n_fail++; $display("FAIL flush_result_held: got %h want 14", bus.result_o); end
      run_op(OP_MUL, 64'd6, 64'd7, res, vcyc, nstall);
      n_checks++;
      if (res !== 64'd42) begin n_fail++; $display("FAIL after_flush_mul: got %h want 42", res); end
   endtask

   task automatic test_async_reset();
      logic [63:0] res;
      int vcyc, nstall;
      @(negedge clk);
      bus.valid_i = 1'b1; bus.op_i = OP_MUL; bus.rs1_i = 64'd3; bus.rs2_i = 64'd5;
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.stall_req_o !== 1'b0 || bus.result_valid_o !== 1'b0 || bus.result_o !== 64'd0) begin
         n_fail++;
         $display("FAIL async_reset: stall %b valid %b result %h want 0 0 0",
                  bus.stall_req_o, bus.result_valid_o, bus.result_o);
      end
      bus.valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_DIVU, 64'd100, 64'd7, res, vcyc, nstall);
      n_checks++;
      if (res !== 64'd14 || vcyc != 65) begin
         n_fail++;
         $display("FAIL after_reset_div: got %h at cycle %0d want 14 at 65", res, vcyc);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r1 = '0, r2 = '0;
      int comps = 0, c2 = -1, drop_at = -1;
      @(negedge clk);
      bus.valid_i = 1'b1; bus.op_i = OP_MUL; bus.rs1_i = 64'd2; bus.rs2_i = 64'd3;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (c == drop_at) bus.valid_i = 1'b0;
         if (bus.result_valid_o) begin
            comps++;
            if (comps == 1) begin
               r1 = bus.result_o;
               bus.rs1_i = 64'd4; bus.rs2_i = 64'd5;
            end else if (comps == 2) begin
               r2 = bus.result_o; c2 = c; drop_at = c + 1;
            end
         end
         @(negedge clk);
      end
      bus.valid_i = 1'b0;
      n_checks++;
      if (comps != 2) begin n_fail++; $display("FAIL b2b_count: %0d completions want 2", comps); end
      n_checks++;
      if (r1 !== 64'd6 || r2 !== 64'd20) begin
         n_fail++;
         $display("FAIL b2b_results: got %h %h want 6 20", r1, r2);
      end
      n_checks++;
      if (c2 != 131) begin n_fail++; $display("FAIL b2b_timing: second valid at %0d want 131", c2); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_word();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
